// File: rtl/ahb_dma_master.sv
// ahb_dma_master: AHB-Lite initiator copying a block of words, one single read then one single write per word.
// Optional AHB_DMA_FIXED_DST_EN adds fixed_dst to hold the destination address for FIFO-style targets.
module ahb_dma_master #(
  parameter int LW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          start,
  input  logic [31:0]   src_addr,
  input  logic [31:0]   dst_addr,
`ifdef AHB_DMA_FIXED_DST_EN
  input  logic          fixed_dst,
`endif
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [3:0]    HPROT,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic          HRESP,
  input  logic [31:0]   HRDATA
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, FIN} state_t;
  state_t state, nxt;
  logic [31:0] src, dst, haddr_q, data_q;
  logic [LW-1:0] cnt;
  logic fix_q, go, rd_ok, wr_ok, dphase;
  assign go     = state == IDLE && start;
  assign dphase = state == RDATA || state == WDATA;
  assign rd_ok  = state == RDATA && HREADY && !HRESP;
  assign wr_ok  = state == WDATA && HREADY && !HRESP;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HWDATA = data_q;
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = len == '0 ? FIN : RADDR;
      RADDR:   if (HREADY) nxt = RDATA;
      RDATA:   if (HREADY) nxt = HRESP ? FIN : WADDR;
      WADDR:   if (HREADY) nxt = WDATA;
      WDATA:   if (HREADY) nxt = (HRESP || cnt == LW'(1)) ? FIN : RADDR;
      default: nxt = IDLE;
    endcase
  end
  // HADDR keeps its last value outside the address phases
  always_comb begin
    HTRANS = (state == RADDR || state == WADDR) ? 2'b10 : 2'b00;
    HWRITE = state == WADDR;
    HADDR  = state == RADDR ? src : state == WADDR ? dst : haddr_q;
  end
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      src     <= '0;
      dst     <= '0;
      cnt     <= '0;
      data_q  <= '0;
      haddr_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      haddr_q <= HADDR;
      done    <= state == FIN;
      if (go) begin
        src  <= src_addr & ~32'h3;
        dst  <= dst_addr & ~32'h3;
        cnt  <= len;
        err  <= 1'b0;
        busy <= 1'b1;
      end else if (state == FIN) busy <= 1'b0;
      if (dphase && HRESP) err <= 1'b1;
      if (rd_ok) begin
        data_q <= HRDATA;
        src    <= src + 32'd4;
      end
      if (wr_ok) begin
        dst <= fix_q ? dst : dst + 32'd4;
        cnt <= cnt - LW'(1);
      end
    end
`ifdef AHB_DMA_FIXED_DST_EN
  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) fix_q <= 1'b0;
    else if (go) fix_q <= fixed_dst;
`else
  assign fix_q = 1'b0;
`endif
endmodule

// File: tb/tb_ahb_dma_master.sv
// tb_ahb_dma_master: bus slave model with read-address and write scoreboards for ahb_dma_master.
// Define AHB_DMA_FIXED_DST_EN to also exercise the fixed destination mode.
module tb_ahb_dma_master;
  logic HCLK = 1'b0, HRESET = 1'b1, start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
`ifdef AHB_DMA_FIXED_DST_EN
  logic fixed_dst = 1'b0;
`endif
  logic busy, done, err, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;
  logic HREADY = 1'b1, HRESP = 1'b0;
  logic [31:0] HRDATA = '0;

  ahb_dma_master #(.LW(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
`ifdef AHB_DMA_FIXED_DST_EN
    .fixed_dst(fixed_dst),
`endif
    .len(len), .busy(busy), .done(done), .err(err), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hC0DE_0000);
  endfunction

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;
  wr_t wq[$];
  logic [31:0] rq[$];
  wr_t e_w;

  // slave state: waits per phase, read index that errors, transfer counters
  int ws = 0, eidx = -1, rd_count = 0, n_ns = 0, left = -1, p_kind = 0;
  logic dp_valid = 1'b0, dp_write = 1'b0, err_step = 1'b0;
  logic p_rdy = 1'b0, p_resp = 1'b0, p_write = 1'b0;
  logic [31:0] dp_addr = '0, p_addr = '0, p_wdata = '0;
  logic [1:0] p_trans = '0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_valid = 1'b0; p_rdy = 1'b0; p_kind = 0; left = -1; err_step = 1'b0;
      HREADY = 1'b1; HRESP = 1'b0;
    end else begin
      if (p_kind != 0 && !p_rdy) begin
        chk("hold_addr", 64'(HADDR), 64'(p_addr));
        chk("hold_trans", 64'(HTRANS), 64'(p_trans));
        chk("hold_wdata", 64'(HWDATA), 64'(p_wdata));
      end
      if (p_rdy && p_kind == 1) begin
        dp_valid = 1'b1; dp_write = p_write; dp_addr = p_addr; n_ns++;
        if (!p_write) begin
          chk("rdq_pending", 64'(rq.size() != 0), 64'd1);
          if (rq.size() != 0) chk("rd_addr", 64'(p_addr), 64'(rq.pop_front()));
        end
      end else if (p_rdy && p_kind == 2) begin
        dp_valid = 1'b0;
        if (dp_write && !p_resp) begin
          mem[dp_addr] = p_wdata;
          chk("wrq_pending", 64'(wq.size() != 0), 64'd1);
          if (wq.size() != 0) begin
            e_w = wq.pop_front();
            chk("wr_addr", 64'(dp_addr), 64'(e_w.a));
            chk("wr_data", 64'(p_wdata), 64'(e_w.d));
          end
        end
        if (!dp_write) rd_count++;
      end
      p_kind = dp_valid ? 2 : (HTRANS == 2'b10 ? 1 : 0);
      HRESP = 1'b0;
      HRDATA = (dp_valid && !dp_write) ? rd(dp_addr) : 32'h0;
      if (p_kind == 2 && !dp_write && rd_count == eidx) begin
        HRESP = 1'b1; HREADY = err_step; err_step = !err_step;
      end else if (p_kind != 0) begin
        if (left < 0) left = ws;
        HREADY = left == 0;
        left--;
      end else HREADY = 1'b1;
      p_rdy = HREADY; p_resp = HRESP; p_addr = HADDR; p_trans = HTRANS;
      p_wdata = HWDATA; p_write = HWRITE;
    end
  end

  task automatic run(input string nm, input logic [31:0] s, input logic [31:0] d, input int l,
                     input int w, input int ei, input int ig, input int fx, input int exp_cyc);
    logic [31:0] sa, da;
    int nr, nw, n;
    logic exp_e;
    sa = s & ~32'h3; da = d & ~32'h3;
    exp_e = ei >= 0 && ei < l;
    nr = exp_e ? ei + 1 : l;
    nw = exp_e ? ei : l;
    ws = w; eidx = ei; rd_count = 0; n_ns = 0;
    for (int i = 0; i < nr; i++) rq.push_back(sa + 32'(4 * i));
    for (int i = 0; i < nw; i++) wq.push_back({fx != 0 ? da : da + 32'(4 * i), rd(sa + 32'(4 * i))});
    src_addr = s; dst_addr = d; len = 16'(l);
`ifdef AHB_DMA_FIXED_DST_EN
    fixed_dst = fx != 0;
`endif
    @(negedge HCLK);
    start = 1'b1;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
      start = 1'b0;
      if (ig != 0 && n == 3) begin
        src_addr = s + 32'h100;
        start = 1'b1;
      end
      if (n == 1) chk({nm, "_busy"}, 64'(busy), 64'd1);
    end while (!done && n < 300);
    chk({nm, "_cycles"}, 64'(n), 64'(exp_cyc));
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    chk({nm, "_err"}, 64'(err), 64'(exp_e));
    @(negedge HCLK);
    chk({nm, "_done_pulse"}, 64'(done), 64'd0);
    chk({nm, "_nonseq"}, 64'(n_ns), 64'(nr + nw));
    chk({nm, "_rdq_left"}, 64'(rq.size()), 64'd0);
    chk({nm, "_wrq_left"}, 64'(wq.size()), 64'd0);
    rq.delete(); wq.delete();
    src_addr = s;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  logic done_seen;
  initial begin
    mem[32'h2000_0000] = 32'hA0;
    mem[32'h2000_0004] = 32'hA1;
    mem[32'h2000_0008] = 32'hA2;
    repeat (2) @(negedge HCLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwdata", 64'(HWDATA), 64'd0);
    chk("const_ctrl", 64'({HSIZE, HBURST, HPROT}), 64'({3'b010, 3'b000, 4'b0011}));
    HRESET = 1'b0;
    @(negedge HCLK);
    run("basic", 32'h2000_0000, 32'h2000_1000, 3, 0, -1, 0, 0, 14);
    run("wait",  32'h2000_0100, 32'h2000_2000, 1, 2, -1, 0, 0, 14);
    run("error", 32'h2000_0200, 32'h2000_3000, 4, 0, 1, 0, 0, 9);
    run("zero",  32'h2000_0300, 32'h2000_3800, 0, 0, -1, 0, 0, 2);
    run("ignore", 32'h2000_0400, 32'h2000_4000, 2, 0, -1, 1, 0, 10);
    run("wrap",  32'hFFFF_FFFE, 32'h3000_0000, 2, 0, -1, 0, 0, 10);
    run("unal",  32'h2000_0503, 32'h2000_5002, 2, 1, -1, 0, 0, 18);
`ifdef AHB_DMA_FIXED_DST_EN
    run("fixed", 32'h2000_0600, 32'h4000_0000, 3, 0, -1, 0, 1, 14);
    run("nofix", 32'h2000_0700, 32'h4000_0100, 2, 0, -1, 0, 0, 10);
`endif
    ws = 0; eidx = -1; rd_count = 0;
    rq.push_back(32'h2000_0800);
    src_addr = 32'h2000_0800; dst_addr = 32'h2000_6000; len = 16'd3;
    @(negedge HCLK);
    start = 1'b1;
    @(negedge HCLK);
    start = 1'b0;
    repeat (3) @(negedge HCLK);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    HRESET = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_htrans", 64'(HTRANS), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_haddr", 64'(HADDR), 64'd0);
    chk("arst_hwdata", 64'(HWDATA), 64'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    rq.delete(); wq.delete();
    n_ns = 0; done_seen = 1'b0;
    repeat (20) begin
      @(negedge HCLK);
      if (done) done_seen = 1'b1;
    end
    chk("arst_no_done", 64'(done_seen), 64'd0);
    chk("arst_no_nonseq", 64'(n_ns), 64'd0);
    chk("arst_idle_busy", 64'(busy), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_dma_master.md
Name: ahb_dma_master

Overview:
AHB-Lite bus initiator that copies a block of 32-bit words from a source address to a destination address. Each word is moved as a single read transfer followed by a single write transfer. It is the master-side counterpart of the SRAM slave bridge and drives the same bus that feeds the SRAM and peripheral slaves. A simple start/busy/done command interface is controlled by a CPU-side register block.

Parameters:
LW, 16, width of the word-count field; the maximum transfer length is 2^LW-1 words.

Ports:
HCLK  input  1  system bus clock
HRESET  input  1  system reset; one clock; reset is asynchronous and active-high
start  input  1  single-cycle command pulse; sampled only in IDLE
src_addr  input  32  source byte address; bits [1:0] ignored and treated as 0
dst_addr  input  32  destination byte address; bits [1:0] ignored and treated as 0
len  input  LW  number of words to copy
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at completion (normal or error)
err  output  1  sticky error flag; set by HRESP=1; cleared by the next accepted start
HADDR  output  32  AHB address
HTRANS  output  2  AHB transfer type; only 2'b00 (IDLE) and 2'b10 (NONSEQ) are used
HWRITE  output  1  AHB write strobe
HSIZE  output  3  constant 3'b010 (word)
HBURST  output  3  constant 3'b000 (SINGLE)
HPROT  output  4  constant 4'b0011
HWDATA  output  32  AHB write data
HREADY  input  1  bus ready
HRESP  input  1  bus error response
HRDATA  input  32  AHB read data

Behaviour:
- Reset values: busy=0, done=0, err=0, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0. Internal: state=IDLE, counters=0, data buffer=0.
- States:
  - IDLE: waits for start. On start:
    - latch src and dst with bits [1:0] forced to 0; latch cnt=len; clear err.
    - len=0: go to FIN; no bus transfers are issued.
    - len>0: go to RADDR.
  - RADDR: drive HADDR=src, HTRANS=10, HWRITE=0. Hold all address/control while HREADY=0. On HREADY=1 go to RDATA.
  - RDATA: HTRANS=00. On HREADY=1 with HRESP=0: capture HRDATA into the buffer; src+=4; go to WADDR.
  - WADDR: drive HADDR=dst, HTRANS=10, HWRITE=1. Hold while HREADY=0. On HREADY=1 go to WDATA.
  - WDATA: HTRANS=00; HWDATA=buffer, held stable until HREADY=1. On HREADY=1 with HRESP=0: dst+=4; cnt-=1. If cnt becomes 0 go to FIN, else go to RADDR.
  - FIN: done=1 for one cycle; busy=0 next cycle; return to IDLE.
- Error response:
  - HRESP=1 in RDATA or WDATA: set err.
  - First error cycle (HREADY=0): keep HTRANS=00.
  - Second cycle (HREADY=1): go to FIN. The remaining words are abandoned and no further NONSEQ is issued.
- HADDR outside RADDR/WADDR holds its last value.
- Latency per word with zero wait states is 4 HCLK cycles. Total for N words is 4N+2 cycles from the start cycle to the done pulse.
- Address arithmetic is modulo 2^32; increments wrap from 0xFFFFFFFC to 0x00000000.
- start while busy is ignored and does not change the latched operands.
- An asynchronous HRESET mid-transfer returns to reset values immediately. No completion is signalled.

Optional Feature:
AHB_DMA_FIXED_DST_EN
- Defined: adds input port fixed_dst (1 bit), latched on an accepted start. When the latched value is 1, dst is not incremented, so all writes go to the same address (peripheral FIFO). When 0, behaviour is normal.
- Undefined: the port is absent and dst always increments by 4.

Test Plan:
- Basic copy: src=0x20000000, dst=0x20001000, len=3, slave with zero wait states and HRDATA=0xA0,0xA1,0xA2 → writes 0xA0,0xA1,0xA2 to 0x20001000/04/08; done pulses exactly 14 cycles after start; err=0.
- Wait states: HREADY low 2 cycles in every address and data phase, len=1 → HADDR, HTRANS and HWDATA stay stable while stalled; memory holds the correct word; done arrives 8 cycles later than the zero-wait case.
- Error: second read gets HRESP=1 (1 cycle with HREADY=0, then 1 cycle with HREADY=1), len=4 → one write completed; err=1; done pulses; no NONSEQ after the error.
- Zero length and ignored start: len=0 → done at cycle 2 with no HTRANS=10. A second start while busy with a different src → ignored; the original transfer completes.
- Wrap and alignment: src=0xFFFFFFFE, len=2 → reads 0xFFFFFFFC then 0x00000000.
- Reset mid-transfer: assert HRESET during WDATA → busy, HTRANS and err return to 0 asynchronously; done does not pulse.
- Fixed destination (AHB_DMA_FIXED_DST_EN defined): fixed_dst=1, len=3 → all three writes go to the dst address.
